// File: rtl/sprite_slot_scheduler_if.sv
// rtl/sprite_slot_scheduler_if.sv - slot position write port between game logic and the scheduler
//
// Signals:
//   wr_valid  master->slave  slot update request
//   wr_ready  slave->master  update accepted when wr_valid & wr_ready
//   wr_slot   master->slave  target slot (slots beyond the configured count are ignored)
//   wr_x      master->slave  sprite x offset in pixels
//   wr_y      master->slave  sprite y offset in pixels
//   wr_en     master->slave  slot visible
interface sprite_slot_scheduler_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_slot;
   logic [6:0] wr_x;
   logic [6:0] wr_y;
   logic       wr_en;

   modport master (
      output wr_valid,
      output wr_slot,
      output wr_x,
      output wr_y,
      output wr_en,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_slot,
      input  wr_x,
      input  wr_y,
      input  wr_en,
      output wr_ready
   );
endinterface

// File: rtl/sprite_slot_scheduler.sv
// rtl/sprite_slot_scheduler.sv - time-multiplexes one sprite ROM across prioritised sprite slots
//
// For every new OLED pixel_index the slots are scanned in priority order (slot 0 on top) through a
// shared 1-cycle-latency sprite ROM; the first enabled, non-transparent colour becomes oled_data,
// otherwise BG_COLOUR. Slot writes land in shadow registers and are copied to the active set only
// when pixel_index wraps to 0, so a frame never shows a half-moved sprite.
//
// Optional feature macro: SPRITE_SCHED_OVERRUN_CNT_EN (saturating count of aborted scans).
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset
//   pixel_index      current OLED pixel from the display driver
//   wr               slot write port (slave modport of sprite_slot_scheduler_if)
//   rom_x, rom_y     offset driven to the shared sprite ROM
//   rom_pixel_index  pixel index driven to the shared sprite ROM
//   rom_data         ROM colour, valid one cycle after the ROM address
//   oled_data        composited pixel colour
//   overrun_count    scans aborted by a pixel_index change
module sprite_slot_scheduler #(
   parameter int          NUM_SPRITES  = 4,
   parameter logic [15:0] TRANSPARENT  = 16'hFDDB,
   parameter logic [15:0] BG_COLOUR    = 16'hFDDB,
   parameter int          FRAME_PIXELS = 6144
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [12:0]             pixel_index,
   sprite_slot_scheduler_if.slave  wr,
   output logic [6:0]              rom_x,
   output logic [6:0]              rom_y,
   output logic [12:0]             rom_pixel_index,
   input  logic [15:0]             rom_data,
   output logic [15:0]             oled_data,
   output logic [7:0]              overrun_count
);

   if (NUM_SPRITES < 1 || NUM_SPRITES > 8 || FRAME_PIXELS < 1 || FRAME_PIXELS > 8192) begin : g_param_check
      $error("sprite_slot_scheduler: NUM_SPRITES must be 1..8 and FRAME_PIXELS 1..8192");
   end

   localparam logic [3:0] LP_NUM = 4'(NUM_SPRITES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Arrays are always 8 deep so a 3-bit slot index addresses them exactly; entries at or above
   // NUM_SPRITES are never written and stay at their reset value.
   logic [6:0]  r_sh_x  [0:7];
   logic [6:0]  r_sh_y  [0:7];
   logic        r_sh_en [0:7];
   logic [6:0]  r_act_x [0:7];
   logic [6:0]  r_act_y [0:7];
   logic        r_act_en[0:7];

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_k;          // scan cycle: slot r_k on the ROM bus, slot r_k-1 being evaluated
   logic [3:0]  w_k_nxt;
   logic [12:0] r_pix_prev;
   logic [12:0] r_pix_cur;
   logic [15:0] r_result;
   logic [15:0] w_result_nxt;
   logic [15:0] r_oled;
   logic [6:0]  r_rom_x;
   logic [6:0]  r_rom_y;
   logic        r_ready;

   logic        w_pix_chg;
   logic        w_commit;
   logic        w_wr_fire;
   logic        w_start;
   logic        w_abort;
   logic        w_res_ld;
   logic        w_oled_ld;
   logic        w_issue;
   logic [2:0]  w_issue_idx;
   logic [2:0]  w_eval_idx;
   logic        w_hit;

   assign w_pix_chg = (pixel_index != r_pix_prev);
   assign w_commit  = (r_pix_prev != 13'd0) && (pixel_index == 13'd0);
   // Ready drops combinationally in the commit cycle so a write can never race the shadow copy.
   assign wr.wr_ready = r_ready && !w_commit;
   assign w_wr_fire   = wr.wr_valid && wr.wr_ready;

   assign w_eval_idx = 3'(r_k - 4'd1);
   assign w_hit      = r_act_en[w_eval_idx] && (rom_data != TRANSPARENT);

   always_comb begin
      w_state_nxt  = r_state;
      w_k_nxt      = r_k;
      w_result_nxt = r_result;
      w_start      = 1'b0;
      w_abort      = 1'b0;
      w_res_ld     = 1'b0;
      w_oled_ld    = 1'b0;
      w_issue      = 1'b0;
      w_issue_idx  = 3'd0;
      case (r_state)
         S_IDLE: begin
            if (w_pix_chg) begin
               w_start = 1'b1;
            end
         end
         S_SCAN: begin
            if (w_pix_chg) begin
               w_start = 1'b1;
               w_abort = 1'b1;
            end else if (r_k != 4'd0 && w_hit) begin
               w_res_ld     = 1'b1;
               w_result_nxt = rom_data;
               w_state_nxt  = S_DONE;
            end else if (r_k == LP_NUM) begin
               w_res_ld     = 1'b1;
               w_result_nxt = BG_COLOUR;
               w_state_nxt  = S_DONE;
            end else begin
               w_k_nxt = r_k + 4'd1;
               if (r_k + 4'd1 < LP_NUM) begin
                  w_issue     = 1'b1;
                  w_issue_idx = 3'(r_k + 4'd1);
               end
            end
         end
         S_DONE: begin
            if (w_pix_chg) begin
               w_start = 1'b1;
               w_abort = 1'b1;
            end else begin
               w_oled_ld   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // A new pixel (from idle or as an abort) always restarts the scan at slot 0.
      if (w_start) begin
         w_state_nxt = S_SCAN;
         w_k_nxt     = 4'd0;
         w_issue     = 1'b1;
         w_issue_idx = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_k        <= 4'd0;
         r_pix_prev <= 13'd0;
         r_pix_cur  <= 13'd0;
         r_result   <= 16'd0;
         r_oled     <= 16'd0;
         r_rom_x    <= 7'd0;
         r_rom_y    <= 7'd0;
         r_ready    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_sh_x[i]   <= 7'd0;
            r_sh_y[i]   <= 7'd0;
            r_sh_en[i]  <= 1'b0;
            r_act_x[i]  <= 7'd0;
            r_act_y[i]  <= 7'd0;
            r_act_en[i] <= 1'b0;
         end
      end else begin
         r_ready <= 1'b1;
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         if (w_start) begin
            r_pix_prev <= pixel_index;
            r_pix_cur  <= pixel_index;
         end
         if (w_issue) begin
            // On the commit edge the active set is being loaded, so slot 0 comes from shadow.
            r_rom_x <= w_commit ? r_sh_x[w_issue_idx] : r_act_x[w_issue_idx];
            r_rom_y <= w_commit ? r_sh_y[w_issue_idx] : r_act_y[w_issue_idx];
         end
         if (w_res_ld) begin
            r_result <= w_result_nxt;
         end
         if (w_oled_ld) begin
            r_oled <= r_result;
         end
         if (w_wr_fire && (int'(wr.wr_slot) < NUM_SPRITES)) begin
            r_sh_x[wr.wr_slot]  <= wr.wr_x;
            r_sh_y[wr.wr_slot]  <= wr.wr_y;
            r_sh_en[wr.wr_slot] <= wr.wr_en;
         end
         if (w_commit) begin
            for (int i = 0; i < 8; i++) begin
               r_act_x[i]  <= r_sh_x[i];
               r_act_y[i]  <= r_sh_y[i];
               r_act_en[i] <= r_sh_en[i];
            end
         end
      end
   end

`ifdef SPRITE_SCHED_OVERRUN_CNT_EN
   logic [7:0] r_overrun;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overrun <= 8'd0;
      end else if (w_abort && r_overrun != 8'hFF) begin
         r_overrun <= r_overrun + 8'd1;
      end
   end

   assign overrun_count = r_overrun;
`else
   assign overrun_count = 8'd0;
`endif

   assign rom_x           = r_rom_x;
   assign rom_y           = r_rom_y;
   assign rom_pixel_index = r_pix_cur;
   assign oled_data       = r_oled;

endmodule
